// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with frame checking, inter-edge timeout and FWFT byte FIFO.
// Define PS2_SCANCODE_TAG_EN to fold E0/F0 prefixes into ext/break tags stored alongside each byte.
module ps2_rx_fifo #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int FIFO_AW         = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ps2_clk,
    input  logic               i_ps2_data,
    input  logic               i_rd,
    input  logic               i_clr_err,
    output logic               o_valid,
    output logic [7:0]         o_data,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_overflow,
    output logic               o_break,
    output logic               o_ext
);
    localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;
`ifdef PS2_SCANCODE_TAG_EN
    localparam int W = 10;
`else
    localparam int W = 8;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              state, state_n;
    logic                c_s1, c_s2, d_s1, d_s2, filt, filt_q, fall;
    logic [DW-1:0]       deb;
    logic [TW-1:0]       tmo;
    logic [7:0]          shreg, shreg_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic                par, par_n;
    logic                timeout, frame_set, par_set, good;
    logic                push_v;
    logic [7:0]          push_d;
    logic                wr_req, wr, pop, full;
    logic [W-1:0]        wr_word, head;
    logic [W-1:0]        mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            filt   <= 1'b1;
            filt_q <= 1'b1;
            deb    <= '0;
        end else begin
            c_s1   <= i_ps2_clk;
            c_s2   <= c_s1;
            d_s1   <= i_ps2_data;
            d_s2   <= d_s1;
            filt_q <= filt;
            if (c_s2 == filt) begin
                deb <= '0;
            end else if (deb == DW'(DEBOUNCE_CYCLES - 1)) begin
                filt <= c_s2;
                deb  <= '0;
            end else begin
                deb <= deb + 1'b1;
            end
        end
    end

    assign fall    = filt_q & ~filt;
    assign timeout = state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        par_n     = par;
        frame_set = 1'b0;
        par_set   = 1'b0;
        good      = 1'b0;
        if (timeout) begin
            state_n   = IDLE;
            frame_set = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    state_n   = d_s2 ? IDLE : DATA;
                    bit_cnt_n = 3'd0;
                end
                DATA: begin
                    shreg_n   = {d_s2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = bit_cnt == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = d_s2;
                    state_n = STOP;
                end
                default: begin
                    state_n   = IDLE;
                    frame_set = !d_s2;
                    par_set   = d_s2 && !(^{shreg, par});
                    good      = d_s2 && (^{shreg, par});
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            tmo     <= '0;
            push_v  <= 1'b0;
            push_d  <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            par     <= par_n;
            tmo     <= (fall || state == IDLE || timeout) ? '0 : tmo + 1'b1;
            push_v  <= good;
            push_d  <= shreg;
        end
    end

`ifdef PS2_SCANCODE_TAG_EN
    logic pend_ext, pend_brk, is_e0, is_f0;
    assign is_e0   = push_d == 8'hE0;
    assign is_f0   = push_d == 8'hF0;
    assign wr_req  = push_v && !is_e0 && !is_f0;
    assign wr_word = {pend_ext, pend_brk, push_d};
    assign o_ext   = o_valid & head[9];
    assign o_break = o_valid & head[8];

    // prefixes accumulate until the next real byte consumes them, even if that byte is dropped
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || frame_set || par_set) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else if (push_v) begin
            pend_ext <= is_e0 | (is_f0 & pend_ext);
            pend_brk <= is_f0 | (is_e0 & pend_brk);
        end
    end
`else
    assign wr_req  = push_v;
    assign wr_word = push_d;
    assign o_ext   = 1'b0;
    assign o_break = 1'b0;
`endif

    assign full    = o_count[FIFO_AW];
    assign pop     = i_rd && o_valid;
    assign wr      = wr_req && (!full || pop);
    assign o_valid = o_count != '0;
    assign head    = mem[rd_ptr];
    assign o_data  = o_valid ? head[7:0] : 8'h00;

    always_ff @(posedge i_clk) begin
        if (wr) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_count      <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            o_count      <= o_count + CW'(wr) - CW'(pop);
            o_parity_err <= par_set ? 1'b1 : i_clr_err ? 1'b0 : o_parity_err;
            o_frame_err  <= frame_set ? 1'b1 : i_clr_err ? 1'b0 : o_frame_err;
            o_overflow   <= (wr_req && full && !pop) ? 1'b1 : i_clr_err ? 1'b0 : o_overflow;
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames against hand-computed FIFO contents and flags.
module tb_ps2_rx_fifo;
    localparam int HALF = 20;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_ps2_clk = 1'b1;
    logic       i_ps2_data = 1'b1;
    logic       i_rd = 1'b0;
    logic       i_clr_err = 1'b0;
    logic       o_valid, o_parity_err, o_frame_err, o_overflow, o_break, o_ext;
    logic [7:0] o_data;
    logic [3:0] o_count;
    int         total = 0;
    int         bad = 0;

    ps2_rx_fifo #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(200), .FIFO_AW(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ps2_clk(i_ps2_clk), .i_ps2_data(i_ps2_data),
        .i_rd(i_rd), .i_clr_err(i_clr_err), .o_valid(o_valid), .o_data(o_data),
        .o_count(o_count), .o_parity_err(o_parity_err), .o_frame_err(o_frame_err),
        .o_overflow(o_overflow), .o_break(o_break), .o_ext(o_ext)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        i_ps2_data = v;
        tick(HALF);
        i_ps2_clk = 1'b0;
        tick(HALF);
        i_ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        tick(HALF);
    endtask

    task automatic rd_chk(input string tag, input int exp);
        chk(tag, o_data, exp);
        i_rd = 1'b1;
        tick(1);
        i_rd = 1'b0;
    endtask

    task automatic clr;
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_data", o_data, 0);
        chk("rst_flags", {o_parity_err, o_frame_err, o_overflow, o_break, o_ext}, 0);
        i_rst_n = 1'b1;
        tick(2);

        send_frame(8'h1C, 0, 1, 11);
        chk("t1_valid", o_valid, 1);
        chk("t1_count", o_count, 1);
        rd_chk("t1_data", 8'h1C);
        chk("t1_empty", o_valid, 0);
        chk("t1_count0", o_count, 0);
        i_rd = 1'b1;
        tick(1);
        i_rd = 1'b0;
        chk("t1_underflow", o_count, 0);

        send_frame(8'h1C, 1, 1, 11);
        chk("t2_count", o_count, 0);
        chk("t2_perr", o_parity_err, 1);
        clr;
        chk("t2_perr_clr", o_parity_err, 0);
        send_frame(8'h32, 0, 1, 11);
        chk("t2_count1", o_count, 1);
        rd_chk("t2_data", 8'h32);

        send_frame(8'h1C, 0, 0, 11);
        chk("t3_ferr", o_frame_err, 1);
        chk("t3_count", o_count, 0);
        chk("t3_perr", o_parity_err, 0);
        clr;
        send_frame(8'h55, 0, 1, 4);
        tick(300);
        chk("t3_tmo_ferr", o_frame_err, 1);
        chk("t3_tmo_count", o_count, 0);
        clr;
        send_frame(8'h45, 0, 1, 11);
        chk("t3_count1", o_count, 1);
        rd_chk("t3_data", 8'h45);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 11);
        chk("t4_count", o_count, 8);
        chk("t4_ovf", o_overflow, 1);
        for (int i = 1; i <= 8; i++) rd_chk("t4_data", i);
        chk("t4_empty", o_valid, 0);
        clr;
        chk("t4_ovf_clr", o_overflow, 0);

        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 1, 11);
        send_frame(8'h09, 0, 1, 10);
        i_ps2_data = 1'b1;
        tick(HALF);
        i_ps2_clk = 1'b0;
        tick(7);
        chk("t5_head", o_data, 1);
        i_rd = 1'b1;
        tick(1);
        i_rd = 1'b0;
        tick(HALF - 8);
        i_ps2_clk = 1'b1;
        tick(HALF);
        chk("t5_count", o_count, 8);
        chk("t5_ovf", o_overflow, 0);
        for (int i = 2; i <= 9; i++) rd_chk("t5_data", i);
        chk("t5_empty", o_valid, 0);

        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'hF0, 0, 1, 11);
        send_frame(8'h75, 0, 1, 11);
`ifdef PS2_SCANCODE_TAG_EN
        chk("t6_count", o_count, 1);
        chk("t6_tags", {o_ext, o_break}, 2'b11);
        rd_chk("t6_data", 8'h75);
`else
        chk("t6_count", o_count, 3);
        chk("t6_tags", {o_ext, o_break}, 0);
        rd_chk("t6_e0", 8'hE0);
        rd_chk("t6_f0", 8'hF0);
        chk("t6_tags75", {o_ext, o_break}, 0);
        rd_chk("t6_75", 8'h75);
`endif
        chk("t6_empty", o_valid, 0);

        send_frame(8'h1C, 0, 1, 4);
        i_rst_n = 1'b0;
        tick(2);
        i_rst_n = 1'b1;
        tick(2);
        chk("t7_count", o_count, 0);
        chk("t7_flags", {o_parity_err, o_frame_err, o_overflow}, 0);
        send_frame(8'h1C, 0, 1, 11);
        chk("t7_count1", o_count, 1);
        rd_chk("t7_data", 8'h1C);
        tick(300);
        chk("t7_noerr", o_frame_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
